instr_cache: RTL and testbench

//  Responder for the fetch stage's instruction read. Direct-mapped, read-only

---
 rtl/icache_pkg.sv | 47 ++++
 rtl/icache_tag_array.sv | 50 +++++
 rtl/instr_cache.sv | 151 +++++++++++++++
 tb/tb_instr_cache.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ============================================================================
//  Module : icache_pkg
//  Brief  : Shared types and address-field helpers for the instruction cache.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package icache_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  // Helpers work on a 64-bit container so any WIDTH up to 64 fits.
  localparam int c_ADDR_MAX = 64;

  function automatic int off_w(input int lw);
    return $clog2(lw) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int width, input int sets, input int lw);
    return width - off_w(lw) - idx_w(sets);
  endfunction

  function automatic logic [c_ADDR_MAX-1:0] addr_word(input logic [c_ADDR_MAX-1:0] a,
                                                      input int lw);
    return (a >> 2) & c_ADDR_MAX'(lw - 1);
  endfunction

  function automatic logic [c_ADDR_MAX-1:0] addr_idx(input logic [c_ADDR_MAX-1:0] a,
                                                     input int sets, input int lw);
    return (a >> off_w(lw)) & c_ADDR_MAX'(sets - 1);
  endfunction

  function automatic logic [c_ADDR_MAX-1:0] addr_tag(input logic [c_ADDR_MAX-1:0] a,
                                                     input int sets, input int lw);
    return a >> (off_w(lw) + idx_w(sets));
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_tag_array.sv
// ============================================================================
//  Module : icache_tag_array
//  Brief  : Valid bits (async reset, bulk clear) and tag storage for the cache.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_tag_array #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [TAG_W-1:0] wtag,
  input  logic             wvalid,
  input  logic [IDX_W-1:0] raddr,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag [SETS];

  // A bulk clear beats a same-cycle write so fence.i can never be lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (clear) begin
      r_valid <= '0;
    end else if (we) begin
      r_valid[waddr] <= wvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      r_tag[waddr] <= wtag;
    end
  end

  assign rvalid = r_valid[raddr];
  assign rtag   = r_tag[raddr];

endmodule

`default_nettype wire

// File: rtl/instr_cache.sv
// ============================================================================
//  Module : instr_cache
//  Brief  : Direct-mapped read-only instruction cache with word-serial refill.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_cache
  import icache_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCF,
  input  logic             invalidate,
  output logic [WIDTH-1:0] InstrF,
  output logic             StallF,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(WIDTH, SETS, LINE_WORDS);
  localparam int BEAT_W = $clog2(LINE_WORDS);

  localparam logic [BEAT_W-1:0] c_LAST     = BEAT_W'(LINE_WORDS - 1);
  localparam logic [WIDTH-1:0]  c_OFF_MASK = WIDTH'((1 << OFF_W) - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [BEAT_W-1:0]   r_beat;
  logic [WIDTH-1:0]    r_base;
  logic                r_kill;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [BEAT_W-1:0]   w_word;
  logic [IDX_W-1:0]    w_base_idx;
  logic [TAG_W-1:0]    w_base_tag;
  logic                w_rvalid;
  logic [TAG_W-1:0]    w_rtag;
  logic [WIDTH-1:0]    w_rdata;
  logic                w_hit;
  logic                w_latch;
  logic                w_ack;
  logic                w_tag_we;
  logic                w_line_ok;

  logic [WIDTH-1:0]    r_data [SETS*LINE_WORDS];

  assign w_word     = BEAT_W'(addr_word(c_ADDR_MAX'(PCF), LINE_WORDS));
  assign w_idx      = IDX_W'(addr_idx(c_ADDR_MAX'(PCF), SETS, LINE_WORDS));
  assign w_tag      = TAG_W'(addr_tag(c_ADDR_MAX'(PCF), SETS, LINE_WORDS));
  assign w_base_idx = IDX_W'(addr_idx(c_ADDR_MAX'(r_base), SETS, LINE_WORDS));
  assign w_base_tag = TAG_W'(addr_tag(c_ADDR_MAX'(r_base), SETS, LINE_WORDS));

  assign w_rdata    = r_data[{w_idx, w_word}];
  // A line whose refill saw an invalidate must not become valid.
  assign w_line_ok  = ~r_kill & ~invalidate;

  icache_tag_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk    (clk),
    .rst    (rst),
    .clear  (invalidate),
    .we     (w_tag_we),
    .waddr  (w_base_idx),
    .wtag   (w_base_tag),
    .wvalid (w_line_ok),
    .raddr  (w_idx),
    .rvalid (w_rvalid),
    .rtag   (w_rtag)
  );

  always_comb begin
    w_state_next = r_state;
    StallF       = 1'b1;
    InstrF       = '0;
    mem_req      = 1'b0;
    mem_addr     = r_base + WIDTH'({r_beat, 2'b00});
    w_hit        = 1'b0;
    w_latch      = 1'b0;
    w_ack        = 1'b0;
    w_tag_we     = 1'b0;
    case (r_state)
      IDLE: begin
        w_hit = w_rvalid & (w_rtag == w_tag) & ~invalidate;
        if (w_hit) begin
          StallF = 1'b0;
          InstrF = w_rdata;
        end else if (!invalidate) begin
          w_latch      = 1'b1;
          w_state_next = REFILL;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_ack = 1'b1;
          if (r_beat == c_LAST) begin
            w_tag_we     = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_base  <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_base <= PCF & ~c_OFF_MASK;
      end
      if (w_ack) begin
        r_beat <= (r_beat == c_LAST) ? '0 : r_beat + 1'b1;
      end
      if (r_state == REFILL) begin
        if (w_ack && (r_beat == c_LAST)) begin
          r_kill <= 1'b0;
        end else if (invalidate) begin
          r_kill <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ack) begin
      r_data[{w_base_idx, r_beat}] <= mem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_cache.sv
// ============================================================================
//  Module : tb_instr_cache
//  Brief  : Directed plus random fetch sequences against a line-level model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_cache;

  localparam int SETS = 16;
  localparam int LW   = 4;
  localparam int LAT  = 3;
  localparam int MEMW = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PCF = '0;
  logic        invalidate = 1'b0;
  logic [31:0] InstrF;
  logic        StallF;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  instr_cache #(
    .WIDTH      (32),
    .SETS       (SETS),
    .LINE_WORDS (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCF        (PCF),
    .invalidate (invalidate),
    .InstrF     (InstrF),
    .StallF     (StallF),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] mem [MEMW];
  logic [31:0] log_q [$];
  int          lat_cnt = 0;

  // Backing memory: acks each request LAT cycles after it appears and logs the address.
  always @(negedge clk) begin
    if (!rst || !mem_req) begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (lat_cnt == LAT - 1) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr[13:2]];
      log_q.push_back(mem_addr);
    end else begin
      lat_cnt = lat_cnt + 1;
    end
  end

  bit          m_valid [SETS];
  logic [23:0] m_tag   [SETS];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
  endtask

  // Waits for the stall to drop and checks the whole refill sequence that caused it.
  task automatic wait_done(input logic [31:0] pc, input int beats);
    int          n;
    logic [31:0] base;
    n    = 0;
    base = pc & ~32'(LW * 4 - 1);
    while (StallF && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_timeout", 32'(StallF), 32'd0);
    chk("refill_beats", 32'(log_q.size()), 32'(beats));
    for (int k = 0; k < log_q.size() && k < beats; k++)
      chk("refill_addr", log_q[k], base + 32'(4 * (k % LW)));
    chk("refill_instr", InstrF, mem[pc[13:2]]);
    chk("refill_req_low", 32'(mem_req), 32'd0);
    m_valid[pc[7:4]] = 1'b1;
    m_tag[pc[7:4]]   = pc[31:8];
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc);
    log_q.delete();
    PCF = pc;
    #1;
    if (m_valid[pc[7:4]] && m_tag[pc[7:4]] == pc[31:8]) begin
      chk("hit_stall", 32'(StallF), 32'd0);
      chk("hit_instr", InstrF, mem[pc[13:2]]);
      chk("hit_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end else begin
      chk("miss_stall", 32'(StallF), 32'd1);
      chk("miss_instr", InstrF, 32'd0);
      wait_done(pc, LW);
    end
  endtask

  task automatic inval_pulse(input logic [31:0] pc);
    PCF        = pc;
    invalidate = 1'b1;
    #1;
    chk("inval_stall", 32'(StallF), 32'd1);
    chk("inval_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    invalidate = 1'b0;
    model_clear();
    #1;
    chk("inval_no_refill", 32'(mem_req), 32'd0);
  endtask

  task automatic wait_log(input int target);
    int n;
    n = 0;
    while (log_q.size() < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("log_timeout", 32'(log_q.size() >= target), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
    for (int i = 0; i < LW; i++) mem[i] = 32'hA0 + 32'(i);
    model_clear();

    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", 32'(StallF), 32'd1);
    chk("reset_instr", InstrF, 32'd0);
    chk("reset_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Cold miss, then same-line hits on consecutive cycles.
    fetch(32'h0);
    chk("cold_word0", InstrF, 32'hA0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);

    // Conflict on index 0 evicts and refills.
    fetch(32'h100);
    fetch(32'h0);

    // fence.i with line 0 valid: forced miss without refill, then a fresh refill.
    inval_pulse(32'h0);
    fetch(32'h0);

    // invalidate on the second beat: the line completes but stays invalid.
    log_q.delete();
    PCF = 32'h200;
    #1;
    chk("kill_miss_stall", 32'(StallF), 32'd1);
    wait_log(1);
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    model_clear();
    wait_done(32'h200, 2 * LW);

    // Reset between beats 1 and 2 aborts the refill.
    log_q.delete();
    PCF = 32'h300;
    wait_log(2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_stall", 32'(StallF), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    fetch(32'h300);

    repeat (300) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 9) == 0) inval_pulse(pc);
      else fetch(pc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
